// File: rtl/gnr_sweep_ctrl.sv
// GRN sweep sequencer: walks every initial state in a range, steps the
// node array and finds each attractor period with Brent cycle detection.
// Ports: clk/rst_n; start + init_first/init_last bound the sweep;
// net_state is the node array s1 vector; reset_nos/init_state load the
// array, start_s0/start_s1 issue the two update phases; res_* is the
// valid/ready result port; busy spans the sweep, done pulses at its end.
module gnr_sweep_ctrl #(
  parameter int N_NODES   = 4,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_first,
  input  logic [N_NODES-1:0] init_last,
  input  logic [N_NODES-1:0] net_state,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [STEP_W-1:0]  res_period,
  output logic [STEP_W-1:0]  res_steps,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PH0,
    S_PH1,
    S_CMP,
    S_EMIT,
    S_NEXT
  } state_e;

  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] ONE   = STEP_W'(1);

  state_e              state_q, state_d;
  logic [N_NODES-1:0]  cur_q, cur_d;
  logic [N_NODES-1:0]  last_q, last_d;
  logic [N_NODES-1:0]  tort_q, tort_d;
  logic [STEP_W-1:0]   power_q, power_d;
  logic [STEP_W-1:0]   lam_q, lam_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                busy_q, busy_d;
  logic [N_NODES-1:0]  rinit_q, rinit_d;
  logic [STEP_W-1:0]   rper_q, rper_d;
  logic [STEP_W-1:0]   rstep_q, rstep_d;
  logic                rtmo_q, rtmo_d;

  logic [STEP_W-1:0]   ln;
  logic [STEP_W-1:0]   steps_inc;
  logic [STEP_W-1:0]   pow_sat;
  logic                hit;
  logic                tmo;
  logic                at_last;

  assign ln        = lam_q + ONE;
  assign steps_inc = steps_q + ONE;
  // Saturate rather than wrap so a huge period never restarts at 0.
  assign pow_sat   = power_q[STEP_W-1] ? '1 : (power_q << 1);
  assign hit       = (net_state == tort_q);
  assign tmo       = (steps_inc == MAX_S);
  assign at_last   = (cur_q == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      tort_q  <= '0;
      power_q <= '0;
      lam_q   <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      rinit_q <= '0;
      rper_q  <= '0;
      rstep_q <= '0;
      rtmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      tort_q  <= tort_d;
      power_q <= power_d;
      lam_q   <= lam_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      rinit_q <= rinit_d;
      rper_q  <= rper_d;
      rstep_q <= rstep_d;
      rtmo_q  <= rtmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = S_PH0;
      S_PH0:  state_d = S_PH1;
      S_PH1:  state_d = S_CMP;
      S_CMP:  state_d = (hit || tmo) ? S_EMIT : S_PH0;
      S_EMIT: if (res_ready) state_d = S_NEXT;
      S_NEXT: state_d = at_last ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_d   = cur_q;
    last_d  = last_q;
    tort_d  = tort_q;
    power_d = power_q;
    lam_d   = lam_q;
    steps_d = steps_q;
    busy_d  = busy_q;
    rinit_d = rinit_q;
    rper_d  = rper_q;
    rstep_d = rstep_q;
    rtmo_d  = rtmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d  = init_first;
          last_d = init_last;
          busy_d = 1'b1;
        end
      end
      S_LOAD: begin
        tort_d  = cur_q;
        power_d = ONE;
        lam_d   = '0;
        steps_d = '0;
      end
      S_CMP: begin
        steps_d = steps_inc;
        // Detection wins over timeout on the same step.
        if (hit) begin
          rinit_d = cur_q;
          rper_d  = ln;
          rstep_d = steps_inc;
          rtmo_d  = 1'b0;
        end else if (tmo) begin
          rinit_d = cur_q;
          rper_d  = '0;
          rstep_d = steps_inc;
          rtmo_d  = 1'b1;
        end else if (ln == power_q) begin
          tort_d  = net_state;
          power_d = pow_sat;
          lam_d   = '0;
        end else begin
          lam_d = ln;
        end
      end
      S_NEXT: begin
        // Compare before increment: init_last of all-ones ends cleanly.
        if (at_last) busy_d = 1'b0;
        else         cur_d  = cur_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    reset_nos   = (state_q == S_LOAD);
    init_state  = reset_nos ? cur_q : '0;
    start_s0    = (state_q == S_PH0);
    start_s1    = (state_q == S_PH1);
    res_valid   = (state_q == S_EMIT);
    res_init    = rinit_q;
    res_period  = rper_q;
    res_steps   = rstep_q;
    res_timeout = rtmo_q;
    busy        = busy_q;
    done        = (state_q == S_NEXT) && at_last;
  end

endmodule
